// File: rtl/hazard_if.sv
// hazard_if: pipeline-to-hazard-controller signal bundle; master = pipeline, slave = hazard_ctrl.
interface hazard_if #(parameter int NUM_SRC = 2);
  logic                   IDEX_valid;
  logic                   IDEX_mem_read;
  logic [4:0]             IDEX_rd;
  logic [5*NUM_SRC-1:0]   IFID_rs;
  logic [NUM_SRC-1:0]     IFID_rs_used;
  logic                   branch_taken;
  logic                   ex_busy;
  logic                   stall_if;
  logic                   stall_id;
  logic                   bubble_ex;
  logic                   flush_if;
  logic                   hold_all;
  modport master (
    output IDEX_valid, IDEX_mem_read, IDEX_rd, IFID_rs, IFID_rs_used, branch_taken, ex_busy,
    input  stall_if, stall_id, bubble_ex, flush_if, hold_all
  );
  modport slave (
    input  IDEX_valid, IDEX_mem_read, IDEX_rd, IFID_rs, IFID_rs_used, branch_taken, ex_busy,
    output stall_if, stall_id, bubble_ex, flush_if, hold_all
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch-flush / multi-cycle-hold arbiter for the rv32i pipeline.
// Optional stall performance counter enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             r_n,
  hazard_if.slave          hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);
  localparam int SBN = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;
  logic [SBN-1:0] sb_v;
  logic [4:0]     sb_rd [SBN];
  logic           idex_load;
  logic           match;
  logic           stall;
  assign idex_load = hz.IDEX_valid & hz.IDEX_mem_read;
  always_comb begin
    match = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (hz.IFID_rs_used[k] && hz.IFID_rs[5*k +: 5] != 5'd0) begin
        if (idex_load && hz.IFID_rs[5*k +: 5] == hz.IDEX_rd) match = 1'b1;
        for (int j = 0; j < SBN; j++)
          if (sb_v[j] && hz.IFID_rs[5*k +: 5] == sb_rd[j]) match = 1'b1;
      end
    end
  end
  // Outputs are forced low the instant reset asserts, independent of the clock.
  assign hz.hold_all  = r_n & hz.ex_busy;
  assign hz.flush_if  = r_n & ~hz.ex_busy & hz.branch_taken;
  assign hz.bubble_ex = r_n & ~hz.ex_busy & (hz.branch_taken | match);
  assign stall        = r_n & ~hz.ex_busy & ~hz.branch_taken & match;
  assign hz.stall_if  = stall;
  assign hz.stall_id  = stall;
  if (LOAD_LAT > 1) begin : g_sb
    always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
        sb_v <= '0;
        for (int j = 0; j < SBN; j++) sb_rd[j] <= 5'd0;
      end else if (!hz.ex_busy) begin
        sb_v[0]  <= idex_load & (hz.IDEX_rd != 5'd0) & ~hz.branch_taken;
        sb_rd[0] <= hz.IDEX_rd;
        for (int j = 1; j < SBN; j++) begin
          sb_v[j]  <= sb_v[j-1];
          sb_rd[j] <= sb_rd[j-1];
        end
      end
    end
  end else begin : g_nosb
    assign sb_v     = '0;
    assign sb_rd[0] = 5'd0;
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) stall_cnt <= '0;
    else if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized + directed scoreboard bench for hazard_ctrl against a queue-based model.
module tb_hazard_ctrl;
  localparam int NUM_SRC  = 2;
  localparam int LOAD_LAT = 3;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  typedef struct packed {
    logic st;
    logic bx;
    logic fi;
    logic ha;
    logic [CNT_W-1:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic r_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  int   hist[$];
  int   p_entry = 0;
  logic p_hold = 1'b0;
  logic p_stall = 1'b0;
  int   cnt_m = 0;
  hazard_if #(.NUM_SRC(NUM_SRC)) hz ();
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
`endif
  hazard_ctrl #(.NUM_SRC(NUM_SRC), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .r_n(r_n),
    .hz(hz)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic model_match(input logic v, input logic ld, input logic [4:0] rd,
                                       input logic [9:0] rs, input logic [1:0] used);
    logic m = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      int r = int'(rs[5*k +: 5]);
      if (used[k] && r != 0) begin
        if (v && ld && r == int'(rd)) m = 1'b1;
        foreach (hist[i]) if (hist[i] == r) m = 1'b1;
      end
    end
    return m;
  endfunction
  task automatic drive(input logic v, input logic ld, input logic [4:0] rd, input logic [9:0] rs,
                       input logic [1:0] used, input logic br, input logic busy);
    exp_t e;
    logic m;
    @(posedge clk);
    if (p_stall && cnt_m < CNT_MAX) cnt_m++;
    if (!p_hold) begin
      hist.push_front(p_entry);
      if (hist.size() > LOAD_LAT - 1) void'(hist.pop_back());
    end
    #1;
    hz.IDEX_valid = v;
    hz.IDEX_mem_read = ld;
    hz.IDEX_rd = rd;
    hz.IFID_rs = rs;
    hz.IFID_rs_used = used;
    hz.branch_taken = br;
    hz.ex_busy = busy;
    m = model_match(v, ld, rd, rs, used);
    e.ha = busy;
    e.fi = !busy && br;
    e.bx = !busy && (br || m);
    e.st = !busy && !br && m;
    e.cnt = CNT_W'(cnt_m);
    q.push_back(e);
    p_hold = busy;
    p_entry = (v && ld && rd != 5'd0 && !br) ? int'(rd) : 0;
    p_stall = e.st;
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e = q.pop_front();
      logic [4:0] act = {hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_if, hz.hold_all};
      logic [4:0] req = {e.st, e.st, e.bx, e.fi, e.ha};
      checks++;
      if (act !== req) begin
        errors++;
        $display("FAIL outputs t=%0t {stall_if,stall_id,bubble_ex,flush_if,hold_all} got=%b want=%b",
                 $time, act, req);
      end
`ifdef HAZARD_PERF_EN
      checks++;
      if (stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt, e.cnt);
      end
`endif
    end
  end
  initial begin
    hz.IDEX_valid = 1'b1;
    hz.IDEX_mem_read = 1'b1;
    hz.IDEX_rd = 5'd5;
    hz.IFID_rs = {5'd0, 5'd5};
    hz.IFID_rs_used = 2'b01;
    hz.branch_taken = 1'b0;
    hz.ex_busy = 1'b0;
    #3;
    checks++;
    if ({hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_if, hz.hold_all} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=00000",
               {hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_if, hz.hold_all});
    end
    hz.IDEX_valid = 1'b0;
    hz.IDEX_mem_read = 1'b0;
    hz.IFID_rs_used = 2'b00;
    repeat (2) @(negedge clk);
    r_n = 1'b1;
    // load rd=5 with dependent rs1=5, then bubbles while dependent waits
    drive(1, 1, 5'd5, {5'd0, 5'd5}, 2'b01, 0, 0);
    repeat (4) drive(0, 0, 5'd0, {5'd0, 5'd5}, 2'b01, 0, 0);
    // load rd=7, dependent on rs2
    drive(1, 1, 5'd7, {5'd7, 5'd1}, 2'b10, 0, 0);
    repeat (4) drive(0, 0, 5'd0, {5'd7, 5'd1}, 2'b10, 0, 0);
    // x0 and unused sources never hazard
    drive(1, 1, 5'd0, {5'd0, 5'd0}, 2'b11, 0, 0);
    drive(1, 1, 5'd9, {5'd9, 5'd9}, 2'b00, 0, 0);
    repeat (3) drive(0, 0, 5'd0, {5'd9, 5'd9}, 2'b11, 0, 0);
    // match and branch together: flush wins, no later stall from that load
    drive(1, 1, 5'd7, {5'd0, 5'd7}, 2'b01, 1, 0);
    repeat (3) drive(0, 0, 5'd0, {5'd0, 5'd7}, 2'b01, 0, 0);
    // ex_busy for 4 cycles during a pending load-use
    drive(1, 1, 5'd7, {5'd0, 5'd7}, 2'b01, 0, 0);
    repeat (4) drive(0, 0, 5'd0, {5'd0, 5'd7}, 2'b01, 1, 1);
    repeat (4) drive(0, 0, 5'd0, {5'd0, 5'd7}, 2'b01, 0, 0);
    // 20 consecutive stalls to reach counter saturation
    repeat (20) drive(1, 1, 5'd5, {5'd0, 5'd5}, 2'b01, 0, 0);
    repeat (3) drive(0, 0, 5'd0, 10'd0, 2'b00, 0, 0);
    for (int n = 0; n < 400; n++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
            {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))}, 2'($urandom_range(0, 3)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
    @(negedge clk);
    #2;
    hz.IDEX_valid = 1'b1;
    hz.IDEX_mem_read = 1'b1;
    hz.IDEX_rd = 5'd5;
    hz.IFID_rs = {5'd0, 5'd5};
    hz.IFID_rs_used = 2'b01;
    hz.branch_taken = 1'b0;
    hz.ex_busy = 1'b0;
    #1;
    checks++;
    if (hz.stall_if !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_stall got=%b want=1", hz.stall_if);
    end
    r_n = 1'b0;
    #1;
    checks++;
    if ({hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_if, hz.hold_all} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset_outputs got=%b want=00000",
               {hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_if, hz.hold_all});
    end
`ifdef HAZARD_PERF_EN
    checks++;
    if (stall_cnt !== '0) begin
      errors++;
      $display("FAIL async_reset_cnt got=%0d want=0", stall_cnt);
    end
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
